// File: rtl/avg_decim.sv
// Integrate-and-dump decimator: averages every DECIM valid samples with
// round-half-up, presenting each result behind a valid/ready output register.
module avg_decim #(
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [24:0]           data_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [24:0]           data_out,
  output logic                  overrun,
  input  logic                  clear_ovr,
  output logic [LOG2_DECIM-1:0] phase
);

  localparam int AW = 25 + LOG2_DECIM;
  localparam int SW = 26 + LOG2_DECIM;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(16777215);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-16777216);

  logic signed [AW-1:0]   r_acc;
  logic [LOG2_DECIM-1:0]  r_phase;
  logic                   r_out_valid;
  logic [24:0]            r_data_out;
  logic                   r_overrun;

  logic                   w_last;
  logic                   w_dump;
  logic                   w_xfer;
  logic                   w_can_load;
  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_rounded;
  logic signed [SW-1:0]   w_shifted;
  logic [24:0]            w_result;

  assign w_last     = (r_phase == LOG2_DECIM'(DECIM - 1));
  assign w_dump     = in_valid && w_last;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_can_load = !r_out_valid || out_ready;

  // One extra bit beyond the accumulator so the rounding bias can never wrap.
  assign w_sum     = {{(SW-AW){r_acc[AW-1]}}, r_acc} + {{(SW-25){data_in[24]}}, data_in};
  assign w_rounded = w_sum + SW'(DECIM / 2);
  assign w_shifted = w_rounded >>> LOG2_DECIM;

  always_comb begin
    w_result = w_shifted[24:0];
    if (w_shifted > SAT_MAX) begin
      w_result = SAT_MAX[24:0];
    end else if (w_shifted < SAT_MIN) begin
      w_result = SAT_MIN[24:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc       <= '0;
      r_phase     <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        if (w_last) begin
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum[AW-1:0];
          r_phase <= r_phase + LOG2_DECIM'(1);
        end
      end

      // A result arriving while the old one is still held is dropped.
      if (w_dump && w_can_load) begin
        r_data_out  <= w_result;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_dump && !w_can_load) begin
        r_overrun <= 1'b1;
      end else if (clear_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign overrun   = r_overrun;
  assign phase     = r_phase;

endmodule

// File: tb/tb_avg_decim.sv
// Self-checking bench for avg_decim: directed scenarios plus randomized traffic
// compared against a frame-queue reference model.
module tb_avg_decim;

  localparam int DECIM      = 4;
  localparam int LOG2_DECIM = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic [24:0]           data_in = '0;
  logic                  out_ready = 1'b0;
  logic                  out_valid;
  logic [24:0]           data_out;
  logic                  overrun;
  logic                  clear_ovr = 1'b0;
  logic [LOG2_DECIM-1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint frame_q[$];
  bit     m_valid;
  longint m_data;
  bit     m_ovr;

  avg_decim #(.DECIM(DECIM), .LOG2_DECIM(LOG2_DECIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .overrun   (overrun),
    .clear_ovr (clear_ovr),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Rounded average with floor division, clamped to 25-bit signed range.
  function automatic longint ref_avg(input longint s);
    longint n;
    longint q;
    n = s + DECIM / 2;
    q = n / DECIM;
    if ((n % DECIM) != 0 && n < 0) q = q - 1;
    if (q > 16777215) q = 16777215;
    if (q < -16777216) q = -16777216;
    return q;
  endfunction

  function automatic longint to_s25(input logic [24:0] v);
    return longint'($signed(v));
  endfunction

  // Advance one clock, update the model from the applied inputs, settle.
  task automatic tick();
    longint sum;
    bit     dumped;
    @(posedge clk);
    dumped = 1'b0;
    if (!reset) begin
      frame_q.delete();
      m_valid = 1'b0;
      m_data  = 0;
      m_ovr   = 1'b0;
    end else begin
      if (in_valid) begin
        frame_q.push_back(to_s25(data_in));
        if (frame_q.size() == DECIM) begin
          sum = 0;
          foreach (frame_q[k]) sum += frame_q[k];
          frame_q.delete();
          dumped = 1'b1;
          if (!m_valid || out_ready) begin
            m_data  = ref_avg(sum);
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
      if (!dumped && m_valid && out_ready) m_valid = 1'b0;
      if (!(dumped && m_ovr && !out_ready && m_valid) && clear_ovr) m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    data_in  = 25'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || phase !== 2'd0 || data_out !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b ovr=%0b ph=%0d d=%0d required all 0", out_valid, overrun, phase, data_out);
    end
    reset = 1'b1;
    $display("reset: v=%0b ovr=%0b phase=%0d", out_valid, overrun, phase);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    feed(1); feed(2); feed(3); feed(4);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== 64'sd3) begin
      n_fail++;
      $display("FAIL basic_avg: got v=%0b d=%0d required v=1 d=3", out_valid, to_s25(data_out));
    end
    $display("basic: 1,2,3,4 -> %0d", to_s25(data_out));
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got v=%0b required 0", out_valid);
    end
  endtask

  task automatic test_negative();
    out_ready = 1'b1;
    feed(-1); feed(-1); feed(-1); feed(-2);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== -64'sd1) begin
      n_fail++;
      $display("FAIL neg_round_a: got v=%0b d=%0d required v=1 d=-1", out_valid, to_s25(data_out));
    end
    $display("negative: -1,-1,-1,-2 -> %0d", to_s25(data_out));
    feed(-2); feed(-2); feed(-2); feed(-1);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== -64'sd2) begin
      n_fail++;
      $display("FAIL neg_round_b: got v=%0b d=%0d required v=1 d=-2", out_valid, to_s25(data_out));
    end
    $display("negative: -2,-2,-2,-1 -> %0d", to_s25(data_out));
    tick();
  endtask

  task automatic test_gaps();
    int vals[7]  = '{5, 0, 0, 7, 0, 9, 11};
    bit vlds[7]  = '{1, 0, 0, 1, 0, 1, 1};
    int phs[7]   = '{1, 1, 1, 2, 2, 3, 0};
    out_ready = 1'b1;
    n_checks++;
    if (phase !== 2'd0) begin
      n_fail++;
      $display("FAIL gap_phase_start: got %0d required 0", phase);
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = vlds[i];
      data_in  = 25'(vals[i]);
      tick();
      n_checks++;
      if (phase !== 2'(phs[i]) || out_valid !== (i == 6)) begin
        n_fail++;
        $display("FAIL gap_step%0d: got ph=%0d v=%0b required ph=%0d v=%0b", i, phase, out_valid, phs[i], (i == 6));
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (to_s25(data_out) !== 64'sd8) begin
      n_fail++;
      $display("FAIL gap_result: got %0d required 8", to_s25(data_out));
    end
    $display("gaps: 5,7,9,11 with gaps -> %0d", to_s25(data_out));
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(100);
      if (i == 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || to_s25(data_out) !== 64'sd100 || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_first: got v=%0b d=%0d ovr=%0b required 1/100/0", out_valid, to_s25(data_out), overrun);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== 64'sd100 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_held: got v=%0b d=%0d ovr=%0b required 1/100/1", out_valid, to_s25(data_out), overrun);
    end
    $display("overrun: held %0d ovr=%0b", to_s25(data_out), overrun);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_take: got v=%0b ovr=%0b required v=0 ovr=1", out_valid, overrun);
    end
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got %0b required 0", overrun);
    end
    $display("overrun: cleared ovr=%0b", overrun);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(16777215);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== 64'sd16777215) begin
      n_fail++;
      $display("FAIL sat_max: got v=%0b d=%0d required 16777215", out_valid, to_s25(data_out));
    end
    $display("extreme: max -> %0d", to_s25(data_out));
    for (int i = 0; i < 4; i++) feed(-16777216);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== -64'sd16777216) begin
      n_fail++;
      $display("FAIL sat_min: got v=%0b d=%0d required -16777216", out_valid, to_s25(data_out));
    end
    $display("extreme: min -> %0d", to_s25(data_out));
    tick();
  endtask

  task automatic test_midframe_reset();
    out_ready = 1'b1;
    feed(50); feed(50);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (phase !== 2'd0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got ph=%0d v=%0b ovr=%0b required 0/0/0", phase, out_valid, overrun);
    end
    for (int i = 0; i < 4; i++) feed(8);
    n_checks++;
    if (out_valid !== 1'b1 || to_s25(data_out) !== 64'sd8) begin
      n_fail++;
      $display("FAIL midreset_result: got v=%0b d=%0d required v=1 d=8", out_valid, to_s25(data_out));
    end
    $display("midframe reset: 8,8,8,8 -> %0d", to_s25(data_out));
    tick();
  endtask

  task automatic test_back_to_back();
    int errs_here = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_in   = 25'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clear_ovr = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 499) != 0);
      tick();
      n_checks++;
      if (out_valid !== m_valid || overrun !== m_ovr || phase !== 2'(frame_q.size()) ||
          to_s25(data_out) !== m_data) begin
        n_fail++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random_cyc%0d: got v=%0b d=%0d ovr=%0b ph=%0d required v=%0b d=%0d ovr=%0b ph=%0d",
                   c, out_valid, to_s25(data_out), overrun, phase, m_valid, m_data, m_ovr, frame_q.size());
      end
    end
    reset = 1'b1; in_valid = 1'b0; clear_ovr = 1'b0;
    $display("random: 3000 cycles, %0d mismatching", errs_here);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_overrun();
    test_saturation();
    test_midframe_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_decim.md
Name: avg_decim

Overview:
- Downstream consumer of the 25-bit signed delay-line output in the sample datapath.
- Integrate-and-dump decimator: accumulates DECIM valid samples, then emits one rounded average per DECIM samples.
- Output sits behind a valid/ready register that holds its value until taken.
- Overruns, where the consumer is too slow, are flagged.

Parameters:
- DECIM, 4, decimation ratio; power of two, legal range 2..16.
- LOG2_DECIM, 2, log2(DECIM); must be consistent with DECIM.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (asserted when 0).
- in_valid  in  1  data_in carries a sample this cycle. No backpressure toward the source.
- data_in  in  25  signed sample.
- out_ready  in  1  consumer accepts data_out this cycle.
- out_valid  out  1  data_out holds an untaken result.
- data_out  out  25  signed rounded average.
- overrun  out  1  sticky flag: a result was dropped.
- clear_ovr  in  1  synchronous clear of overrun.
- phase  out  LOG2_DECIM  number of samples accumulated in the current frame.

Behaviour:
- Reset (reset==0 at a clk edge):
  - acc, phase, out_valid, data_out and overrun all go to 0.
  - Takes priority over every other input, including mid-frame: any partial accumulation is discarded.
- Accumulator: signed, 25+LOG2_DECIM bits wide; it cannot overflow.
- On each edge with in_valid==1:
  - If phase < DECIM-1: acc <= acc + data_in, and phase increments.
  - If phase == DECIM-1 (dump):
    - sum = acc + data_in, computed at full width.
    - result = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM. This is an arithmetic shift, giving round-half-toward-+inf.
    - Computed at 26+LOG2_DECIM bits, then saturated to the 25-bit range [-16777216, 16777215]. Saturation is a defensive clamp and is unreachable for legal inputs.
    - acc <= 0 and phase <= 0 in the same cycle. The next sample starts a new frame with no lost cycle.
- in_valid==0: acc and phase hold. Gaps of any length are legal.
- Latency: the result is on data_out with out_valid==1 in the cycle after the edge that accepts the DECIM-th sample.
- Output handshake: a transfer occurs on an edge where out_valid && out_ready.
  - Dump while out_valid==0: load data_out and set out_valid.
  - Dump while a transfer occurs in the same cycle: load the new result, and out_valid stays 1.
  - Dump while out_valid==1 and out_ready==0:
    - The new result is discarded and data_out holds the old value.
    - overrun <= 1.
    - Accumulation restarts normally.
  - Transfer with no dump: out_valid <= 0. data_out holds its last value (don't-care while out_valid==0).
- data_out must not change while out_valid==1 and out_ready==0.
- overrun: set on an overrun event, cleared by clear_ovr. If both happen in the same cycle, set wins.
- Module is fully synchronous: single clock, no combinational path from inputs to outputs.

Test Plan:
- DECIM=4, out_ready=1. Inputs 1,2,3,4 on consecutive cycles -> one cycle after the 4th sample, out_valid=1 and data_out=3 ((10+2)>>>2). The following cycle out_valid=0.
- Inputs -1,-1,-1,-2 -> data_out=-1 ((-5+2)>>>2). Inputs -2,-2,-2,-1 -> data_out=-2 ((-7+2)>>>2). Both check rounding of negatives.
- Inputs 5,gap,gap,7,gap,9,11 with in_valid low on the gaps -> exactly one output, 8, appearing one cycle after the 11 is accepted. phase reads 0,1,1,1,2,2,3,0 across the sequence.
- out_ready=0, feed 8 samples of 100 -> first result 100 held and overrun=1 after the 8th sample; the second result is lost. Then out_ready=1 for one cycle -> 100 taken, out_valid=0. Pulse clear_ovr -> overrun=0.
- Continuous 16777215 for 4 samples -> 16777215. Continuous -16777216 -> -16777216. Neither result may wrap.
- Feed 2 samples of 50, drive reset=0 for one cycle -> phase=0, out_valid=0, overrun=0. Then 4 samples of 8 -> data_out=8, with no trace of the 50s.
